// File: rtl/change_dispenser.sv
// Coin change dispenser: greedy selection over 10/5/2/1 Rs ejectors with
// per-denomination inventory, fixed-width eject pulses and inter-coin gaps.
module change_dispenser #(
  parameter int PULSE_CYCLES = 10,
  parameter int GAP_CYCLES   = 4,
  parameter int INV_INIT     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] amount,
  input  logic       refill,
  output logic       ready,
  output logic       eject_01,
  output logic       eject_02,
  output logic       eject_05,
  output logic       eject_10,
  output logic       done,
  output logic       fault,
  output logic [3:0] shortfall,
  output logic [3:0] inv_empty,
  output logic [2:0] state_dbg
);

  // Handshake: req/amount and refill are taken on a rising edge only when
  // ready=1 (IDLE); anything presented while ready=0 is dropped, not queued.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] INV_LOAD   = 4'(INV_INIT);

  state_t     state;
  logic [3:0] remaining;
  logic [3:0] cnt;
  logic [1:0] sel;
  logic [3:0] ejects;
  logic [3:0] inv_01, inv_02, inv_05, inv_10;

  logic       pick_valid;
  logic [1:0] pick_idx;

  // Coin index encoding: 0=1 Rs, 1=2 Rs, 2=5 Rs, 3=10 Rs.
  function automatic logic [3:0] coin_value(input logic [1:0] idx);
    case (idx)
      2'd0:    coin_value = 4'd1;
      2'd1:    coin_value = 4'd2;
      2'd2:    coin_value = 4'd5;
      default: coin_value = 4'd10;
    endcase
  endfunction

  // Greedy pick: largest stocked denomination not exceeding the remainder.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    if (remaining >= 4'd10 && inv_10 != 4'd0) begin
      pick_valid = 1'b1;
      pick_idx   = 2'd3;
    end else if (remaining >= 4'd5 && inv_05 != 4'd0) begin
      pick_valid = 1'b1;
      pick_idx   = 2'd2;
    end else if (remaining >= 4'd2 && inv_02 != 4'd0) begin
      pick_valid = 1'b1;
      pick_idx   = 2'd1;
    end else if (remaining >= 4'd1 && inv_01 != 4'd0) begin
      pick_valid = 1'b1;
      pick_idx   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ready     <= 1'b1;
      remaining <= 4'd0;
      cnt       <= 4'd0;
      sel       <= 2'd0;
      ejects    <= 4'd0;
      done      <= 1'b0;
      fault     <= 1'b0;
      shortfall <= 4'd0;
      inv_01    <= INV_LOAD;
      inv_02    <= INV_LOAD;
      inv_05    <= INV_LOAD;
      inv_10    <= INV_LOAD;
    end else begin
      case (state)
        S_IDLE: begin
          if (refill) begin
            inv_01 <= INV_LOAD;
            inv_02 <= INV_LOAD;
            inv_05 <= INV_LOAD;
            inv_10 <= INV_LOAD;
          end
          if (req) begin
            remaining <= amount;
            ready     <= 1'b0;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (remaining == 4'd0) begin
            done      <= 1'b1;
            fault     <= 1'b0;
            shortfall <= 4'd0;
            state     <= S_DONE;
          end else if (pick_valid) begin
            sel    <= pick_idx;
            ejects <= 4'b0001 << pick_idx;
            cnt    <= 4'd0;
            state  <= S_PULSE;
          end else begin
            done      <= 1'b1;
            fault     <= 1'b1;
            shortfall <= remaining;
            state     <= S_DONE;
          end
        end
        S_PULSE: begin
          if (cnt == PULSE_LAST) begin
            // Coin is only counted as paid once its pulse has fully completed.
            ejects    <= 4'd0;
            cnt       <= 4'd0;
            remaining <= remaining - coin_value(sel);
            case (sel)
              2'd0:    inv_01 <= inv_01 - 4'd1;
              2'd1:    inv_02 <= inv_02 - 4'd1;
              2'd2:    inv_05 <= inv_05 - 4'd1;
              default: inv_10 <= inv_10 - 4'd1;
            endcase
            state <= S_GAP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= 4'd0;
            state <= S_SELECT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ejects <= 4'd0;
          done   <= 1'b0;
          ready  <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign eject_01  = ejects[0];
  assign eject_02  = ejects[1];
  assign eject_05  = ejects[2];
  assign eject_10  = ejects[3];
  assign inv_empty = {inv_10 == 4'd0, inv_05 == 4'd0, inv_02 == 4'd0, inv_01 == 4'd0};
  assign state_dbg = state;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter PULSE_CYCLES, default 10, SHALL set the eject-pulse width in clk cycles (legal 1..15).
REQ-002 Parameter GAP_CYCLES, default 4, SHALL set the all-ejects-low gap after each pulse (legal 1..15).
REQ-003 Parameter INV_INIT, default 8, SHALL set the per-denomination coin inventory loaded at reset and refill (legal 0..15).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset; synchronous, active-high; clock clk.
REQ-006 req  input  1  change request; sampled only while ready=1.
REQ-007 amount  input  4  change value in Rs (0..15); captured with req.
REQ-008 refill  input  1  reload all inventories; honoured only while ready=1.
REQ-009 ready  output  1  idle and accepting req/refill.
REQ-010 eject_01, eject_02, eject_05, eject_10  output  1 each  coin-ejector drive, one per denomination, at most one high.
REQ-011 done  output  1  one-cycle completion strobe.
REQ-012 fault  output  1  last request not fully paid.
REQ-013 shortfall  output  4  unpaid remainder of last request.
REQ-014 inv_empty  output  4  bit3..0 = inventory zero for 10/5/2/1 Rs.

Function
REQ-015 The FSM SHALL have states IDLE, SELECT, PULSE, GAP and DONE; ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, req=1 SHALL latch amount into a 4-bit remaining register and enter SELECT on the next cycle; req=0 SHALL keep IDLE.
REQ-017 In SELECT, if remaining=0 the FSM SHALL enter DONE with fault=0 and shortfall=0.
REQ-018 In SELECT, the FSM SHALL pick the largest denomination d in {10,5,2,1} with d<=remaining and inventory(d)>0, and enter PULSE.
REQ-019 In SELECT, if remaining>0 and no denomination qualifies, the FSM SHALL enter DONE with fault=1 and shortfall=remaining.
REQ-020 Selection SHALL be greedy only; no backtracking to find an exact combination.
REQ-021 In PULSE, exactly the selected eject_d SHALL be high for PULSE_CYCLES consecutive cycles, then GAP SHALL be entered.
REQ-022 On the last PULSE cycle, inventory(d) SHALL decrement by 1 and remaining SHALL decrement by d; no underflow is possible.
REQ-023 In GAP, all eject outputs SHALL be low for GAP_CYCLES cycles, then SELECT SHALL be re-entered.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-025 fault and shortfall SHALL be updated on DONE entry and held until the next DONE entry.
REQ-026 With req accepted at edge E0 (cycle 0), done SHALL be high in cycle 2 + n*(PULSE_CYCLES+GAP_CYCLES+1), where n is the number of coins ejected.
REQ-027 amount=0 SHALL complete with n=0: done in cycle 2, fault=0, no ejects.
REQ-028 req and refill high together in IDLE: refill SHALL load inventories first, then the request SHALL proceed using the refilled values.
REQ-029 req and refill while ready=0 SHALL be ignored and not queued.
REQ-030 Refill SHALL set all four inventories to INV_INIT; inventories SHALL never exceed 15.
REQ-031 inv_empty SHALL reflect the registered inventories combinationally.

Reset
REQ-032 rst SHALL force IDLE, remaining=0, all ejects=0, done=0, fault=0, shortfall=0 and all inventories=INV_INIT on the next rising clk edge.
REQ-033 rst asserted mid-PULSE SHALL drop the eject line on that edge and SHALL NOT decrement inventory for the aborted coin.
REQ-034 rst SHALL take priority over req and refill.

Verification
REQ-035 After reset with defaults, amount=6 -> eject_05 high in cycles 2-11, eject_01 high in cycles 17-26, done in cycle 32, fault=0, inv_empty=0000.
REQ-036 amount=15 -> ejects in order 10, 5; done in cycle 32; inventories 10/5 at 7.
REQ-037 Drain the 5 and 1 inventories, then request amount=6 -> three eject_02 pulses, done in cycle 47, fault=0.
REQ-038 Only 2-Rs coins in stock, amount=3 -> one eject_02, then done with fault=1, shortfall=1.
REQ-039 rst in cycle 5 of the first PULSE for amount=10 -> eject_10 low on the next cycle, ready=1, all inventories=8.
REQ-040 req pulsed during GAP and refill pulsed during PULSE -> both ignored; the current request completes unchanged and the inventories are not reloaded.
